shoot_through_monitor: RTL

Supervisory controller for the half-bridge gate-drive path. It synchronises the asynchronous high-side and low-side gate-command monitor inputs with 2-flop stages. It qualifies overlap of the two commands, latches a shoot-through fault and removes both gate permissives. It re-arms only after an explicit clear followed by a verified quiet period. It sits between the gate-command taps and the gate-driver enable logic, and reports fault and dead-time events to the status register file.

---
 rtl/shoot_through_if.sv | 25 ++
 rtl/shoot_through_monitor.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/shoot_through_if.sv
// Gate-command monitor bus between the gate-command taps / driver-enable logic and the shoot-through supervisor.
interface shoot_through_if #(
    parameter int CNT_W = 8
) ();
    logic             hs_in;
    logic             ls_in;
    logic             enable;
    logic             clear;
    logic             hs_en;
    logic             ls_en;
    logic             fault;
    logic             dt_warn;
    logic [CNT_W-1:0] fault_cnt;
    logic [1:0]       state;

    modport master (
        output hs_in, ls_in, enable, clear,
        input  hs_en, ls_en, fault, dt_warn, fault_cnt, state
    );

    modport slave (
        input  hs_in, ls_in, enable, clear,
        output hs_en, ls_en, fault, dt_warn, fault_cnt, state
    );
endinterface

// File: rtl/shoot_through_monitor.sv
// Half-bridge shoot-through supervisor: latches overlap faults, drops gate permissives, re-arms after clear + quiet.
// Optional dead-time advisory checker is built when SHOOT_THROUGH_DEADTIME_CHECK_EN is defined.
module shoot_through_monitor #(
    parameter int OVERLAP_CYCLES = 3,
    parameter int DEADTIME_MIN   = 8,
    parameter int REARM_CYCLES   = 16,
    parameter int CNT_W          = 8
) (
    input logic            clk,
    input logic            rst,
    shoot_through_if.slave bus
);
    localparam int OV_W = $clog2(OVERLAP_CYCLES) + 1;
    localparam int QT_W = $clog2(REARM_CYCLES) + 1;
    localparam logic [OV_W-1:0] OV_LAST = OV_W'(OVERLAP_CYCLES - 1);
    localparam logic [QT_W-1:0] QT_LAST = QT_W'(REARM_CYCLES - 1);

    if (OVERLAP_CYCLES < 1 || OVERLAP_CYCLES > 255) begin : g_bad_ov
        $error("OVERLAP_CYCLES must be 1..255");
    end
    if (DEADTIME_MIN < 1 || DEADTIME_MIN > 255) begin : g_bad_dt
        $error("DEADTIME_MIN must be 1..255");
    end
    if (REARM_CYCLES < 1 || REARM_CYCLES > 255) begin : g_bad_ra
        $error("REARM_CYCLES must be 1..255");
    end

    typedef enum logic [1:0] {
        DISABLED = 2'd0,
        ARMED    = 2'd1,
        FAULT    = 2'd2,
        REARM    = 2'd3
    } state_t;

    state_t           state_q, state_n;
    logic             hs_m, ls_m, hs_s, ls_s;
    logic             both_hi, both_lo;
    logic [OV_W-1:0]  ov_cnt, ov_cnt_n;
    logic [QT_W-1:0]  quiet_cnt, quiet_cnt_n;
    logic [CNT_W-1:0] fault_cnt_q, fault_cnt_n;
    logic             perm_q, fault_q;

    // Two-flop synchronisers on the asynchronous gate-command taps
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hs_m <= 1'b0;
            hs_s <= 1'b0;
            ls_m <= 1'b0;
            ls_s <= 1'b0;
        end else begin
            hs_m <= bus.hs_in;
            hs_s <= hs_m;
            ls_m <= bus.ls_in;
            ls_s <= ls_m;
        end
    end

    assign both_hi = hs_s & ls_s;
    assign both_lo = ~hs_s & ~ls_s;

    // Counters default to zero so any state change clears them
    always_comb begin
        state_n     = state_q;
        ov_cnt_n    = '0;
        quiet_cnt_n = '0;
        fault_cnt_n = fault_cnt_q;
        case (state_q)
            DISABLED: begin
                if (bus.enable) state_n = ARMED;
            end
            ARMED: begin
                if (both_hi && ov_cnt == OV_LAST) begin
                    state_n     = FAULT;
                    fault_cnt_n = (&fault_cnt_q) ? fault_cnt_q : fault_cnt_q + 1'b1;
                end else if (!bus.enable) begin
                    state_n = DISABLED;
                end else if (both_hi) begin
                    ov_cnt_n = ov_cnt + 1'b1;
                end
            end
            FAULT: begin
                if (bus.clear) state_n = REARM;
            end
            REARM: begin
                if (both_lo) begin
                    if (quiet_cnt == QT_LAST) begin
                        state_n = bus.enable ? ARMED : DISABLED;
                    end else begin
                        quiet_cnt_n = quiet_cnt + 1'b1;
                    end
                end
            end
            default: state_n = DISABLED;
        endcase
    end

    // Outputs are registered from the next state so they change on the transition edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= DISABLED;
            ov_cnt      <= '0;
            quiet_cnt   <= '0;
            fault_cnt_q <= '0;
            perm_q      <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_n;
            ov_cnt      <= ov_cnt_n;
            quiet_cnt   <= quiet_cnt_n;
            fault_cnt_q <= fault_cnt_n;
            perm_q      <= (state_n == ARMED);
            fault_q     <= (state_n == FAULT) || (state_n == REARM);
        end
    end

    assign bus.hs_en     = perm_q;
    assign bus.ls_en     = perm_q;
    assign bus.fault     = fault_q;
    assign bus.fault_cnt = fault_cnt_q;
    assign bus.state     = state_q;

`ifdef SHOOT_THROUGH_DEADTIME_CHECK_EN
    localparam int GP_W = $clog2(DEADTIME_MIN) + 1;
    localparam logic [GP_W-1:0] GP_MAX = GP_W'(DEADTIME_MIN);

    logic            hs_d, ls_d, last_ls, seen, dt_hit, dt_warn_q;
    logic [GP_W-1:0] gap_cnt;

    // A rise is only a violation when the opposite side was the last one high; seen masks the post-reset case
    assign dt_hit = (state_q == ARMED) && seen && (gap_cnt < GP_MAX) &&
                    ((hs_s && !hs_d && last_ls) || (ls_s && !ls_d && !last_ls));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hs_d      <= 1'b0;
            ls_d      <= 1'b0;
            last_ls   <= 1'b0;
            seen      <= 1'b0;
            gap_cnt   <= '0;
            dt_warn_q <= 1'b0;
        end else begin
            hs_d      <= hs_s;
            ls_d      <= ls_s;
            dt_warn_q <= dt_hit;
            if (hs_s || ls_s) begin
                gap_cnt <= '0;
                seen    <= 1'b1;
            end else if (gap_cnt != GP_MAX) begin
                gap_cnt <= gap_cnt + 1'b1;
            end
            if (hs_s && !ls_s) last_ls <= 1'b0;
            else if (ls_s && !hs_s) last_ls <= 1'b1;
        end
    end

    assign bus.dt_warn = dt_warn_q;
`else
    assign bus.dt_warn = 1'b0;
`endif
endmodule
